// File: rtl/cpu_pio_pkg.sv
// cpu_pio_pkg: shared register offsets, edge encodings and clog2 helper for the input PIO
package cpu_pio_pkg;

   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   typedef enum logic [1:0] {
      EDGE_RISING  = 2'd0,
      EDGE_FALLING = 2'd1,
      EDGE_ANY     = 2'd2
   } edge_type_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/pio_input_conditioner.sv
// pio_input_conditioner: one-bit synchroniser, debounce counter and stable register
module pio_input_conditioner
   import cpu_pio_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_in,
   output logic o_stable,
   output logic o_next_stable
);

   localparam int CW = (clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_next;
   logic                   r_stable;
   logic                   w_next_stable;
   logic                   w_sync_out;

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   // accept a change only after it has disagreed with stable for DEBOUNCE_CYCLES edges
   always_comb begin
      w_next_stable = r_stable;
      w_cnt_next    = '0;
      if (DEBOUNCE_CYCLES == 0) begin
         w_next_stable = w_sync_out;
      end else if (w_sync_out != r_stable) begin
         if (r_cnt == CNT_LAST) w_next_stable = w_sync_out;
         else w_cnt_next = r_cnt + CW'(1);
      end
   end

   // synchroniser chain, debounce count and stable value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync   <= '0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], i_in};
         r_cnt    <= w_cnt_next;
         r_stable <= w_next_stable;
      end
   end

   assign o_stable      = r_stable;
   assign o_next_stable = w_next_stable;

endmodule

// File: rtl/cpu_input_pio_irq.sv
// cpu_input_pio_irq: parametrised input PIO with synchroniser, debounce, edge capture and maskable irq
module cpu_input_pio_irq
   import cpu_pio_pkg::*;
#(
   parameter int WIDTH           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_next_stable;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] r_edge_capture;
   logic [31:0]      r_readdata;
   logic [31:0]      w_rd_mux;
   logic             w_wr;
   logic             w_unused;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_input_conditioner #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cond (
         .clk          (clk),
         .reset        (reset),
         .i_in         (in_port[i]),
         .o_stable     (w_stable[i]),
         .o_next_stable(w_next_stable[i])
      );
   end

   assign w_wr     = chipselect & ~write_n;
   assign w_clr    = (w_wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign w_unused = &{1'b0, writedata};

   // edge detect looks ahead at next_stable so capture lands on the same edge stable changes
   always_comb begin
      w_edge = (EDGE_TYPE == int'(EDGE_FALLING)) ? (w_stable & ~w_next_stable) :
               (EDGE_TYPE == int'(EDGE_ANY))     ? (w_stable ^ w_next_stable)  :
                                                   (~w_stable & w_next_stable);
   end

   // read mux; reserved offset and bits above WIDTH read as zero
   always_comb begin
      w_rd_mux = (address == PIO_ADDR_DATA)    ? 32'(w_stable)       :
                 (address == PIO_ADDR_IRQMASK) ? 32'(r_irqmask)      :
                 (address == PIO_ADDR_EDGECAP) ? 32'(r_edge_capture) : '0;
   end

   // irqmask, edge capture (set beats write-1-clear) and latency-1 read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irqmask      <= '0;
         r_edge_capture <= '0;
         r_readdata     <= '0;
      end else begin
         if (w_wr && address == PIO_ADDR_IRQMASK) r_irqmask <= writedata[WIDTH-1:0];
         r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
         r_readdata     <= w_rd_mux;
      end
   end

   assign readdata = r_readdata;
   assign irq      = |(r_edge_capture & r_irqmask);

endmodule
